// File: rtl/kbd_pkg.sv
// Shared constants and state types for the PS/2 matrix keyboard emulator.
package kbd_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT   = 8'hAA;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;

    // Bytes that follow E1 in the Pause sequence and carry no key meaning.
    localparam int unsigned PAUSE_SKIP = 7;

    typedef enum logic [2:0] {
        DecBase,
        DecExt,
        DecBrk,
        DecExtBrk,
        DecPause
    } dec_state_e;

    typedef enum logic {
        RxIdle,
        RxData
    } rx_state_e;

    // Keyboard responses and fillers that never reach the matrix.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchroniser, clock glitch filter, frame FSM and watchdog.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned FILT_CYC    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       err_stb
);

    localparam int unsigned FW = $clog2(FILT_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_s, dat_s;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          clk_filt_q, clk_filt_d;
    logic          fall;

    rx_state_e     state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [7:0]    rx_byte_d;
    logic          byte_stb_d, err_stb_d;
    logic          wd_expired;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Filtered clock only flips after FILT_CYC consecutive samples disagree with it.
    always_comb begin
        filt_cnt_d = '0;
        clk_filt_d = clk_filt_q;
        if (clk_s != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILT_CYC - 1)) begin
                clk_filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall       = clk_filt_q & ~clk_filt_d;
    assign wd_expired = (wd_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_cnt_q <= '0;
            clk_filt_q <= 1'b1;
            state_q    <= RxIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wd_q       <= '0;
            rx_byte    <= '0;
            byte_stb   <= 1'b0;
            err_stb    <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            filt_cnt_q <= filt_cnt_d;
            clk_filt_q <= clk_filt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            rx_byte    <= rx_byte_d;
            byte_stb   <= byte_stb_d;
            err_stb    <= err_stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RxIdle: if (fall && !dat_s) state_d = RxData;
            RxData: begin
                if (fall) begin
                    if (bit_cnt_q == 4'd9) state_d = RxIdle;
                end else if (wd_expired) begin
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // bit_cnt 0..7 data, 8 parity, 9 stop; shift_q holds {parity, data} LSB-first.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wd_d       = '0;
        rx_byte_d  = rx_byte;
        byte_stb_d = 1'b0;
        err_stb_d  = 1'b0;
        unique case (state_q)
            RxIdle: bit_cnt_d = '0;
            RxData: begin
                if (fall) begin
                    if (bit_cnt_q != 4'd9) begin
                        shift_d   = {dat_s, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (dat_s && (^shift_q)) begin
                        rx_byte_d  = shift_q[7:0];
                        byte_stb_d = 1'b1;
                    end else begin
                        err_stb_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    err_stb_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard to open-drain key matrix emulator with external scan-code map.
module ps2_matrix_kbd
    import kbd_pkg::*;
#(
    parameter int unsigned ROWS        = 6,
    parameter int unsigned COLS        = 12,
    parameter int unsigned FILT_CYC    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter bit          CTRL_MASK   = 1'b1,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    input  logic            clear,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [8:0]      map_code,
    input  logic            map_hit,
    input  logic [RW-1:0]   map_row,
    input  logic [CW-1:0]   map_col,
    output logic [2:0]      mods,
    output logic            key_event,
    output logic            key_make,
    output logic            frame_err
);

    logic [7:0] rx_byte;
    logic       byte_stb;

    ps2_rx #(
        .FILT_CYC   (FILT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .rx_byte (rx_byte),
        .byte_stb(byte_stb),
        .err_stb (frame_err)
    );

    dec_state_e dec_q, dec_d;
    logic [2:0] skip_q, skip_d;

    logic key_vld, key_mk, key_ext, bat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_q  <= DecBase;
            skip_q <= '0;
        end else begin
            dec_q  <= dec_d;
            skip_q <= skip_d;
        end
    end

    always_comb begin
        dec_d  = dec_q;
        skip_d = skip_q;
        if (byte_stb) begin
            unique case (dec_q)
                DecBase: begin
                    if (rx_byte == PS2_EXT) begin
                        dec_d = DecExt;
                    end else if (rx_byte == PS2_BRK) begin
                        dec_d = DecBrk;
                    end else if (rx_byte == PS2_PAUSE) begin
                        dec_d  = DecPause;
                        skip_d = 3'(PAUSE_SKIP);
                    end
                end
                DecExt:    dec_d = (rx_byte == PS2_BRK) ? DecExtBrk : DecBase;
                DecBrk:    dec_d = DecBase;
                DecExtBrk: dec_d = DecBase;
                DecPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) dec_d = DecBase;
                end
                default:   dec_d = DecBase;
            endcase
        end
    end

    always_comb begin
        key_vld = 1'b0;
        key_mk  = 1'b1;
        bat     = 1'b0;
        key_ext = (dec_q == DecExt) || (dec_q == DecExtBrk);
        if (byte_stb) begin
            unique case (dec_q)
                DecBase: begin
                    if (rx_byte == PS2_BAT) begin
                        bat = 1'b1;
                    end else if (rx_byte != PS2_EXT && rx_byte != PS2_BRK &&
                                 rx_byte != PS2_PAUSE && !is_ignored(rx_byte)) begin
                        key_vld = 1'b1;
                    end
                end
                DecExt:    key_vld = (rx_byte != PS2_BRK);
                DecBrk,
                DecExtBrk: begin
                    key_vld = 1'b1;
                    key_mk  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign map_code = {key_ext, rx_byte};

    // Modifier bits: {ralt, lalt, rctrl, lctrl, rshift, lshift}
    logic [5:0] mod_q, mod_d;
    logic [ROWS-1:0][COLS-1:0] matrix_q, matrix_d;
    logic ctrl_held, in_range, apply, release_all;
    logic event_d, make_d;

    assign ctrl_held   = mod_q[2] | mod_q[3];
    assign in_range    = (32'(map_row) < ROWS) && (32'(map_col) < COLS);
    assign apply       = key_vld && map_hit && in_range && !(key_mk && CTRL_MASK && ctrl_held);
    assign release_all = clear | bat;

    always_comb begin
        matrix_d = matrix_q;
        event_d  = 1'b0;
        make_d   = key_make;
        if (release_all) begin
            matrix_d = '0;
        end else if (apply) begin
            matrix_d[map_row][map_col] = key_mk;
            event_d = 1'b1;
            make_d  = key_mk;
        end
    end

    always_comb begin
        mod_d = mod_q;
        if (release_all) begin
            mod_d = '0;
        end else if (key_vld) begin
            if (!key_ext && rx_byte == KEY_LSHIFT) mod_d[0] = key_mk;
            if (!key_ext && rx_byte == KEY_RSHIFT) mod_d[1] = key_mk;
            if (!key_ext && rx_byte == KEY_CTRL)   mod_d[2] = key_mk;
            if (key_ext  && rx_byte == KEY_CTRL)   mod_d[3] = key_mk;
            if (!key_ext && rx_byte == KEY_ALT)    mod_d[4] = key_mk;
            if (key_ext  && rx_byte == KEY_ALT)    mod_d[5] = key_mk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix_q  <= '0;
            mod_q     <= '0;
            key_event <= 1'b0;
            key_make  <= 1'b0;
        end else begin
            matrix_q  <= matrix_d;
            mod_q     <= mod_d;
            key_event <= event_d;
            key_make  <= make_d;
        end
    end

    assign mods = {mod_q[5] | mod_q[4], mod_q[3] | mod_q[2], mod_q[1] | mod_q[0]};

    always_comb begin
        col_out = '1;
        row_out = '1;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (matrix_q[r][c] && !row_in[r]) col_out[c] = 1'b0;
                if (matrix_q[r][c] && !col_in[c]) row_out[r] = 1'b0;
            end
        end
    end

endmodule
